// File: rtl/pixel_fifo_n.sv
// -----------------------------------------------------------------------------
// pixel_fifo_n
//
// Parametrised pixel FIFO between a fetcher (producer) and the mixer/framebuffer
// (consumer). One write moves a burst of BURST pixels into the FIFO. One read
// pops a single pixel. The FIFO has two write modes:
//   - append: the burst is placed behind the current contents.
//   - overlay merge: a transparent existing pixel (colour 0) is replaced by an
//     opaque new pixel. Any slot past the current occupancy is filled. This mode
//     lets the same block serve as the OBJ FIFO.
//
// Optional feature, controlled by the macro PIXEL_FIFO_DISCARD_EN:
//   When the macro is defined, the ports discard_start and discard_n are added.
//   A discard_start pulse loads a down-counter. While that counter is non-zero,
//   the FIFO drops one pixel per cycle internally. During this time it looks
//   empty to the consumer and external reads are ignored. This implements
//   SCX fine-scroll discard.
//
// Parameters:
//   PIXEL_W  pixel width; bits [1:0] are the colour index, 0 = transparent
//   DEPTH    number of entries (power of two, >= BURST)
//   BURST    pixels per write
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   flush          empties the FIFO on the next edge
//   wr_en          write strobe
//   wr_merge       0 = append, 1 = overlay merge
//   wr_data        burst; slice [PIXEL_W-1:0] is pixel 0 (output first)
//   full           count > DEPTH-BURST
//   overrun        one-cycle pulse after a dropped append
//   rd_en          pop strobe
//   rd_data        head pixel (fall-through), 0 when empty
//   empty          count == 0 (or discard in progress)
//   count          occupancy
//   discard_start  (PIXEL_FIFO_DISCARD_EN only) load the discard counter
//   discard_n      (PIXEL_FIFO_DISCARD_EN only) number of pixels to discard
// -----------------------------------------------------------------------------
module pixel_fifo_n #(
  parameter int PIXEL_W = 8,
  parameter int DEPTH   = 16,
  parameter int BURST   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic                       wr_merge,
  input  logic [BURST*PIXEL_W-1:0]   wr_data,
  output logic                       full,
  output logic                       overrun,
  input  logic                       rd_en,
  output logic [PIXEL_W-1:0]         rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef PIXEL_FIFO_DISCARD_EN
  ,
  input  logic                       discard_start,
  input  logic [2:0]                 discard_n
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // A pixel is transparent when its colour index is 0.
  function automatic logic is_clear(input logic [PIXEL_W-1:0] px);
    return (px[1:0] == 2'd0);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PIXEL_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      head_r;
  logic [CW-1:0]      count_r;
  logic               overrun_r;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic               raw_empty_s;
  logic               busy_s;
  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               append_s;
  logic               merge_s;
  logic               drop_s;
  logic [AW-1:0]      head_pop_s;
  logic [CW-1:0]      cnt_pop_s;
  logic [CW-1:0]      count_next_s;
  logic               wr_we_s  [BURST];
  logic [AW-1:0]      wr_idx_s [BURST];
  logic [PIXEL_W-1:0] wr_px_s  [BURST];

`ifdef PIXEL_FIFO_DISCARD_EN
  logic [2:0]         discard_ctr_r;

  // The discard counter is non-zero while a fine-scroll discard is in progress.
  always_comb begin
    busy_s = (discard_ctr_r != 3'd0);
  end
`else
  // Without the discard feature, the FIFO is never busy discarding.
  always_comb begin
    busy_s = 1'b0;
  end
`endif

  // Status flags come only from registered state.
  // A discard in progress hides the FIFO contents from the consumer.
  always_comb begin
    raw_empty_s = (count_r == {CW{1'b0}});
    full_s      = (count_r > CW'(DEPTH - BURST));
    empty_s     = raw_empty_s | busy_s;
  end

  // Work out the pop, then the write, then the occupancy after this edge.
  // The write operates on the contents left after any same-cycle pop.
  always_comb begin
    // While discarding, the internal pop replaces the external rd_en.
    pop_s      = !raw_empty_s && (busy_s || rd_en);
    head_pop_s = head_r + AW'(pop_s);
    cnt_pop_s  = count_r - CW'(pop_s);

    // full uses the count before this edge.
    // An append is therefore dropped even if a pop would have made room.
    append_s = wr_en && !wr_merge && !full_s;
    merge_s  = wr_en && wr_merge;
    drop_s   = wr_en && !wr_merge && full_s;

    if (append_s) begin
      count_next_s = cnt_pop_s + CW'(BURST);
    end else if (merge_s) begin
      count_next_s = (cnt_pop_s > CW'(BURST)) ? cnt_pop_s : CW'(BURST);
    end else begin
      count_next_s = cnt_pop_s;
    end
  end

  // Per-pixel write enable, slot index and data for the burst.
  always_comb begin
    for (int k = 0; k < BURST; k++) begin
      wr_we_s[k]  = 1'b0;
      wr_idx_s[k] = {AW{1'b0}};
      wr_px_s[k]  = wr_data[k*PIXEL_W +: PIXEL_W];
      if (append_s) begin
        // Append only happens when not full.
        // Then cnt_pop_s < DEPTH, so its low bits are the exact offset.
        wr_we_s[k]  = 1'b1;
        wr_idx_s[k] = head_pop_s + cnt_pop_s[AW-1:0] + AW'(k);
      end else if (merge_s) begin
        wr_idx_s[k] = head_pop_s + AW'(k);
        if (CW'(k) < cnt_pop_s) begin
          // Existing pixel wins unless it is transparent and the new one is not.
          wr_we_s[k] = is_clear(mem_r[head_pop_s + AW'(k)]) &&
                       !is_clear(wr_data[k*PIXEL_W +: PIXEL_W]);
        end else begin
          wr_we_s[k] = 1'b1;
        end
      end else begin
        wr_we_s[k] = 1'b0;
      end
    end
  end

  // Pointer, occupancy and overrun registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r    <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      overrun_r <= 1'b0;
    end else if (flush) begin
      head_r    <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      head_r    <= head_pop_s;
      count_r   <= count_next_s;
      overrun_r <= drop_s;
    end
  end

  // Storage array. The contents are don't-care after reset, so the array is
  // written only for real writes. The BURST slots in one write never collide,
  // because BURST <= DEPTH.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int k = 0; k < BURST; k++) begin
        if (wr_we_s[k]) begin
          mem_r[wr_idx_s[k]] <= wr_px_s[k];
        end
      end
    end
  end

`ifdef PIXEL_FIFO_DISCARD_EN
  // Fine-scroll discard down-counter.
  // A new start reloads the counter, even while a discard is already running.
  // The counter decrements only on cycles where a pixel is actually dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_ctr_r <= 3'd0;
    end else if (flush) begin
      discard_ctr_r <= 3'd0;
    end else if (discard_start) begin
      discard_ctr_r <= discard_n;
    end else if (busy_s && pop_s) begin
      discard_ctr_r <= discard_ctr_r - 3'd1;
    end else begin
      discard_ctr_r <= discard_ctr_r;
    end
  end
`endif

  // Output drive. The head pixel falls through and reads 0 when hidden or empty.
  always_comb begin
    full    = full_s;
    empty   = empty_s;
    count   = count_r;
    overrun = overrun_r;
    if (empty_s) begin
      rd_data = {PIXEL_W{1'b0}};
    end else begin
      rd_data = mem_r[head_r];
    end
  end

endmodule

// File: tb/tb_pixel_fifo_n.sv
module tb_pixel_fifo_n;

  localparam int PW = 8;
  localparam int DP = 16;
  localparam int BS = 8;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          wr_en;
  logic          wr_merge;
  logic [BS*PW-1:0] wr_data;
  logic          full;
  logic          overrun;
  logic          rd_en;
  logic [PW-1:0] rd_data;
  logic          empty;
  logic [4:0]    count;
`ifdef PIXEL_FIFO_DISCARD_EN
  logic          discard_start;
  logic [2:0]    discard_n;
`endif

  int checks = 0;
  int errors = 0;

  pixel_fifo_n #(.PIXEL_W(PW), .DEPTH(DP), .BURST(BS)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_merge(wr_merge),
    .wr_data(wr_data), .full(full), .overrun(overrun), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .count(count)
`ifdef PIXEL_FIFO_DISCARD_EN
    , .discard_start(discard_start), .discard_n(discard_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle, so that outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Burst whose pixel k equals first+k.
  function automatic logic [BS*PW-1:0] seq_burst(input logic [PW-1:0] first);
    logic [BS*PW-1:0] b;
    b = '0;
    for (int k = 0; k < BS; k++) b[k*PW +: PW] = first + PW'(k);
    return b;
  endfunction

  task automatic idle();
    flush = 1'b0; wr_en = 1'b0; wr_merge = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef PIXEL_FIFO_DISCARD_EN
    discard_start = 1'b0; discard_n = 3'd0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic append(input logic [BS*PW-1:0] d);
    wr_en = 1'b1; wr_merge = 1'b0; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
  endtask

  task automatic test_append_drain();
    do_reset();
    append(seq_burst(8'h01));
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL ad_count: got %0d expected 8", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL ad_full_at_8: got %b expected 0", full); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== 8'(i + 1)) begin errors++; $display("FAIL ad_rd_data[%0d]: got %h expected %h", i, rd_data, 8'(i + 1)); end
      pop();
      checks++; if (count !== 5'(7 - i)) begin errors++; $display("FAIL ad_count[%0d]: got %0d expected %0d", i, count, 7 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ad_empty_end: got %b expected 1", empty); end
    pop();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ad_pop_empty: got %0d expected 0", count); end
  endtask

  task automatic test_full_overrun();
    do_reset();
    append(seq_burst(8'h11));
    append(seq_burst(8'h21));
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fo_count16: got %0d expected 16", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fo_full: got %b expected 1", full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fo_no_overrun: got %b expected 0", overrun); end
    append(seq_burst(8'h31));
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fo_overrun: got %b expected 1", overrun); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fo_count_kept: got %0d expected 16", count); end
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fo_overrun_pulse: got %b expected 0", overrun); end
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fo_head: got %h expected 11", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] exp;
    do_reset();
    append(seq_burst(8'h11));
    rd_en = 1'b1; wr_en = 1'b1; wr_merge = 1'b0; wr_data = seq_burst(8'h21);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL bb_count: got %0d expected 15", count); end
    checks++; if (rd_data !== 8'h12) begin errors++; $display("FAIL bb_head: got %h expected 12", rd_data); end
    for (int i = 0; i < 15; i++) begin
      exp = (i < 7) ? 8'(8'h12 + i) : 8'(8'h21 + i - 7);
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL bb_order[%0d]: got %h expected %h", i, rd_data, exp); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bb_empty: got %b expected 1", empty); end
  endtask

  task automatic test_merge();
    logic [PW-1:0] exp [8];
    do_reset();
    // Pixels 5..7 have colours {0,2,0}; the first five are popped away.
    append({8'h68, 8'h56, 8'h44, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10});
    for (int i = 0; i < 5; i++) pop();
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL mg_pre_count: got %0d expected 3", count); end
    wr_en = 1'b1; wr_merge = 1'b1;
    wr_data = {8'h9F, 8'h9B, 8'h97, 8'h93, 8'h8F, 8'h8B, 8'h87, 8'h83};
    tick();
    wr_en = 1'b0; wr_merge = 1'b0;
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL mg_count: got %0d expected 8", count); end
    exp = '{8'h83, 8'h56, 8'h8B, 8'h8F, 8'h93, 8'h97, 8'h9B, 8'h9F};
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== exp[i]) begin errors++; $display("FAIL mg_slot[%0d]: got %h expected %h", i, rd_data, exp[i]); end
      pop();
    end
  endtask

  task automatic test_flush();
    do_reset();
    append(seq_burst(8'h01));
    for (int i = 0; i < 4; i++) pop();
    append(seq_burst(8'h21));
    checks++; if (count !== 5'd12) begin errors++; $display("FAIL fl_pre_count: got %0d expected 12", count); end
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = seq_burst(8'h41);
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fl_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fl_empty: got %b expected 1", empty); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fl_overrun: got %b expected 0", overrun); end
    append(seq_burst(8'h31));
    checks++; if (rd_data !== 8'h31) begin errors++; $display("FAIL fl_next_head: got %h expected 31", rd_data); end
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL fl_next_count: got %0d expected 8", count); end
  endtask

  task automatic test_reset_mid();
    append(seq_burst(8'h51));
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = seq_burst(8'h61);
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rm_empty: got %b expected 1", empty); end
  endtask

`ifdef PIXEL_FIFO_DISCARD_EN
  task automatic test_discard();
    do_reset();
    append(seq_burst(8'h01));
    discard_start = 1'b1; discard_n = 3'd3;
    tick();
    discard_start = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dc_empty0: got %b expected 1", empty); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL dc_rd_zero: got %h expected 00", rd_data); end
    rd_en = 1'b1;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dc_empty1: got %b expected 1", empty); end
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL dc_count1: got %0d expected 7", count); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dc_empty2: got %b expected 1", empty); end
    rd_en = 1'b0;
    tick();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL dc_empty3: got %b expected 0", empty); end
    checks++; if (rd_data !== 8'h04) begin errors++; $display("FAIL dc_first: got %h expected 04", rd_data); end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL dc_count: got %0d expected 5", count); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_append_drain();
    test_full_overrun();
    test_back_to_back();
    test_merge();
    test_flush();
    test_reset_mid();
`ifdef PIXEL_FIFO_DISCARD_EN
    test_discard();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
